// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: turns loads/stores into data-memory requests and extends load data.
// Latency: a memory op occupies k+2 cycles (k = cycles from request to dmem_resp, k>=1); non-memory ops 1 cycle.
// Backpressure: mem_stall holds every pipeline register from op arrival until the response edge; DONE releases it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_*                     instruction fields from the EX/MEM register (frozen while mem_stall=1)
//   dmem_addr/rmask/wmask/wdata  registered request to data memory; a nonzero mask means a request is live
//   dmem_rdata, dmem_resp    response from data memory (resp is a one-cycle pulse)
//   mem_wb_data              value forwarded to MEM/WB (extended load data, else ex_alu_out)
//   mem_stall                hold all pipeline registers
//   mem_misaligned           current memory op is misaligned and is being dropped

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] mem_wb_data,
    output logic        mem_stall,
    output logic        mem_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Latched op fields: everything the request and the extension need lives
    // here, so nothing downstream depends on the EX/MEM inputs staying put.
    logic [31:0] addr_q,    addr_d;
    logic [2:0]  funct3_q,  funct3_d;
    logic        is_load_q, is_load_d;

    // Registered request outputs and captured response word.
    logic [3:0]  rmask_q,   rmask_d;
    logic [3:0]  wmask_q,   wmask_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [31:0] rdata_q,   rdata_d;

    // ------------------------------------------------------------------
    // Decode of the incoming op (only consulted in IDLE)
    // ------------------------------------------------------------------
    logic [1:0]  ex_lane;
    logic        ex_mem_op;
    logic        ex_aligned;
    logic [3:0]  ex_mask;
    logic [31:0] ex_wdata_shifted;

    assign ex_lane   = ex_alu_out[1:0];
    assign ex_mem_op = ex_valid & (ex_is_load | ex_is_store);

    // funct3[1:0] selects the access size: 00 byte, 01 half, 1x word.
    always_comb begin
        ex_aligned = 1'b1;
        ex_mask    = 4'b0000;
        unique case (ex_funct3[1:0])
            2'b00: begin
                ex_aligned = 1'b1;
                ex_mask    = 4'b0001 << ex_lane;
            end
            2'b01: begin
                ex_aligned = (ex_lane[0] == 1'b0);
                ex_mask    = 4'b0011 << ex_lane;
            end
            default: begin
                ex_aligned = (ex_lane == 2'b00);
                ex_mask    = 4'b1111;
            end
        endcase
    end

    assign ex_wdata_shifted = ex_rs2_data << {ex_lane, 3'b000};

    // ------------------------------------------------------------------
    // Load extension from the captured word and the latched op fields
    // ------------------------------------------------------------------
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    assign rdata_shifted = rdata_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        unique case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b100:  load_ext = {24'h000000,              rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {16'h0000,                rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        funct3_d       = funct3_q;
        is_load_d      = is_load_q;
        rmask_d        = rmask_q;
        wmask_d        = wmask_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        mem_stall      = 1'b0;
        mem_misaligned = 1'b0;
        mem_wb_data    = ex_alu_out;

        unique case (state_q)
            IDLE: begin
                // A response pulse here belongs to nothing we issued; ignore it.
                if (ex_mem_op) begin
                    if (ex_aligned) begin
                        mem_stall = 1'b1;
                        addr_d    = ex_alu_out;
                        funct3_d  = ex_funct3;
                        is_load_d = ex_is_load;
                        // Load wins if both flags are set so only one mask is ever live.
                        if (ex_is_load) begin
                            rmask_d = ex_mask;
                            wmask_d = 4'b0000;
                        end else begin
                            rmask_d = 4'b0000;
                            wmask_d = ex_mask;
                        end
                        wdata_d = ex_wdata_shifted;
                        state_d = REQ;
                    end else begin
                        mem_misaligned = 1'b1;
                    end
                end
            end

            REQ: begin
                mem_stall = 1'b1;
                if (dmem_resp) begin
                    rdata_d = dmem_rdata;
                    rmask_d = 4'b0000;
                    wmask_d = 4'b0000;
                    state_d = DONE;
                end
            end

            DONE: begin
                // The pipeline advances at the end of this cycle; no request
                // can be issued here, so the next op starts from IDLE.
                if (is_load_q) begin
                    mem_wb_data = load_ext;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            funct3_q  <= 3'b000;
            is_load_q <= 1'b0;
            rmask_q   <= 4'b0000;
            wmask_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            is_load_q <= is_load_d;
            rmask_q   <= rmask_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_rmask = rmask_q;
    assign dmem_wmask = wmask_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2_data;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_wb_data;
    logic        mem_stall;
    logic        mem_misaligned;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_load     (ex_is_load),
        .ex_is_store    (ex_is_store),
        .ex_funct3      (ex_funct3),
        .ex_alu_out     (ex_alu_out),
        .ex_rs2_data    (ex_rs2_data),
        .dmem_addr      (dmem_addr),
        .dmem_rmask     (dmem_rmask),
        .dmem_wmask     (dmem_wmask),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_resp      (dmem_resp),
        .mem_wb_data    (mem_wb_data),
        .mem_stall      (mem_stall),
        .mem_misaligned (mem_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-cycle expectations set by the driver, checked on the falling edge.
    bit          chk_en   = 1'b0;
    bit          chk_wb   = 1'b0;
    bit          chk_addr = 1'b0;
    bit          chk_wdat = 1'b0;
    bit          exp_stall;
    bit          exp_mis;
    logic [3:0]  exp_rmask;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;

    // Observations of the DUT for the directed literal checks.
    int          stall_cnt;
    int          win_cnt;
    int          mis_cnt;
    bit          prev_active;
    logic [3:0]  cap_rmask;
    logic [3:0]  cap_wmask;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] cap_wb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % access_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] m;
        int         lane;
        m    = 4'b0000;
        lane = int'(a % 4);
        for (int b = 0; b < access_bytes(f3); b++) m[lane + b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [31:0] a);
        return rs2 * (32'd1 << (8 * (a % 4)));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v;
        int          nb;
        nb = access_bytes(f3);
        v  = word / (32'd1 << (8 * (a % 4)));
        if (nb == 4) return v;
        v = v % (32'd1 << (8 * nb));
        if (f3[2] == 1'b0 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall});
            check("mem_misaligned", {31'b0, mem_misaligned}, {31'b0, exp_mis});
            check("dmem_rmask", {28'b0, dmem_rmask}, {28'b0, exp_rmask});
            check("dmem_wmask", {28'b0, dmem_wmask}, {28'b0, exp_wmask});
            if (chk_addr) check("dmem_addr", dmem_addr, exp_addr);
            if (chk_wdat) check("dmem_wdata", dmem_wdata, exp_wdata);
            if (chk_wb)   check("mem_wb_data", mem_wb_data, exp_wb);
        end
        if (dmem_rmask != 4'b0 || dmem_wmask != 4'b0) begin
            if (!prev_active) win_cnt++;
            cap_rmask = dmem_rmask;
            cap_wmask = dmem_wmask;
            cap_addr  = dmem_addr;
            cap_wdata = dmem_wdata;
        end
        prev_active = (dmem_rmask != 4'b0 || dmem_wmask != 4'b0);
        if (mem_stall) stall_cnt++;
        else           cap_wb = mem_wb_data;
        if (mem_misaligned) mis_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        stall_cnt = 0;
        win_cnt   = 0;
        mis_cnt   = 0;
        cap_rmask = 4'b0;
        cap_wmask = 4'b0;
        cap_addr  = 32'h0;
        cap_wdata = 32'h0;
        cap_wb    = 32'h0;
    endtask

    task automatic set_idle_exp(input logic [31:0] alu, input bit mis);
        chk_en    = 1'b1;
        exp_stall = 1'b0;
        exp_mis   = mis;
        exp_rmask = 4'b0;
        exp_wmask = 4'b0;
        chk_addr  = 1'b0;
        chk_wdat  = 1'b0;
        chk_wb    = 1'b1;
        exp_wb    = alu;
    endtask

    // Drives one instruction from arrival until the pipeline advances past it.
    task automatic do_op(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input int k,
                         input logic [31:0] rd, input bit spur);
        bit         mem;
        logic [3:0] m;
        mem         = v && (ld || st);
        ex_valid    = v;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_alu_out  = alu;
        ex_rs2_data = rs2;
        dmem_rdata  = $urandom;
        if (!mem || !model_aligned(f3, alu)) begin
            dmem_resp = spur;
            set_idle_exp(alu, mem);
            step();
            dmem_resp = 1'b0;
        end else begin
            dmem_resp = 1'b0;
            set_idle_exp(alu, 1'b0);
            exp_stall = 1'b1;
            chk_wb    = 1'b0;
            step();
            m = model_mask(f3, alu);
            for (int i = 1; i <= k; i++) begin
                exp_rmask  = ld ? m : 4'b0;
                exp_wmask  = ld ? 4'b0 : m;
                chk_addr   = 1'b1;
                exp_addr   = alu - (alu % 4);
                chk_wdat   = !ld;
                exp_wdata  = model_wdata(rs2, alu);
                dmem_resp  = (i == k);
                dmem_rdata = (i == k) ? rd : $urandom;
                step();
            end
            dmem_resp = 1'b0;
            set_idle_exp(ld ? model_load(f3, alu, rd) : alu, 1'b0);
            step();
        end
        chk_en = 1'b0;
    endtask

    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] rd_lw;

    initial begin
        rst         = 1'b1;
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
        ex_funct3   = 3'b000;
        ex_alu_out  = 32'h1234;
        ex_rs2_data = 32'h0;
        dmem_rdata  = 32'h0;
        dmem_resp   = 1'b0;
        prev_active = 1'b0;
        clear_caps();

        // Reset state: request registers zero, pass-through of ex_alu_out.
        step();
        step();
        set_idle_exp(32'h1234, 1'b0);
        chk_addr  = 1'b1; exp_addr  = 32'h0;
        chk_wdat  = 1'b1; exp_wdata = 32'h0;
        step();
        rst = 1'b0;
        step();
        chk_en = 1'b0;

        // LB / LBU at 0x1003, memory returns 0x80000000 after 3 cycles.
        clear_caps();
        do_op(1, 1, 0, 3'b000, 32'h1003, 32'h0, 3, 32'h8000_0000, 0);
        check("lb_addr", cap_addr, 32'h1000);
        check("lb_rmask", {28'b0, cap_rmask}, 32'h8);
        check("lb_stall_cycles", stall_cnt, 4);
        check("lb_wb", cap_wb, 32'hFFFF_FF80);
        clear_caps();
        do_op(1, 1, 0, 3'b100, 32'h1003, 32'h0, 3, 32'h8000_0000, 0);
        check("lbu_wb", cap_wb, 32'h0000_0080);

        // SH at 0x2002, k=1.
        clear_caps();
        do_op(1, 0, 1, 3'b001, 32'h2002, 32'h0000_ABCD, 1, 32'h0, 0);
        check("sh_addr", cap_addr, 32'h2000);
        check("sh_wmask", {28'b0, cap_wmask}, 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCD_0000);
        check("sh_stall_cycles", stall_cnt, 2);
        check("sh_wb", cap_wb, 32'h2002);

        // Misaligned LW is dropped.
        clear_caps();
        do_op(1, 1, 0, 3'b010, 32'h3001, 32'h0, 2, 32'h0, 0);
        check("mis_pulses", mis_cnt, 1);
        check("mis_windows", win_cnt, 0);
        check("mis_stall_cycles", stall_cnt, 0);

        // ADD, then back-to-back LW / SW with k=2.
        clear_caps();
        do_op(1, 0, 0, 3'b000, 32'h55, 32'h0, 1, 32'h0, 0);
        check("add_stall_cycles", stall_cnt, 0);
        check("add_wb", cap_wb, 32'h55);
        clear_caps();
        rd_lw = $urandom;
        do_op(1, 1, 0, 3'b010, 32'h40, 32'h0, 2, rd_lw, 0);
        check("lw_windows", win_cnt, 1);
        check("lw_wb", cap_wb, rd_lw);
        clear_caps();
        do_op(1, 0, 1, 3'b010, 32'h44, 32'hDEAD_BEEF, 2, 32'h0, 0);
        check("sw_windows", win_cnt, 1);
        check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);

        // Spurious response while idle.
        clear_caps();
        do_op(1, 0, 0, 3'b000, 32'h77, 32'h0, 1, 32'h0, 1);
        do_op(1, 0, 0, 3'b000, 32'h78, 32'h0, 1, 32'h0, 0);
        check("spur_stall_cycles", stall_cnt, 0);
        check("spur_windows", win_cnt, 0);

        // Reset while a response is outstanding; late response ignored.
        ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'b010;
        ex_alu_out = 32'h50; dmem_resp = 0;
        step();
        rst = 1'b1; ex_valid = 1'b0;
        step();
        set_idle_exp(32'h50, 1'b0);
        step();
        rst = 1'b0;
        step();
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_resp = 1'b0;
        step();
        chk_en = 1'b0;
        clear_caps();
        rd_lw = $urandom;
        do_op(1, 1, 0, 3'b010, 32'h60, 32'h0, 1, rd_lw, 0);
        check("post_reset_lw_wb", cap_wb, rd_lw);

        // Randomized mix.
        for (int n = 0; n < 200; n++) begin
            int          r;
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r < 3) begin
                do_op($urandom_range(0, 1), $urandom_range(0, 1) == 0 ? 1'b0 : (r == 0),
                      1'b0, 3'($urandom_range(0, 7)), a, $urandom, 1, 32'h0,
                      $urandom_range(0, 3) == 0);
                if (r != 0) begin
                    // r==0 may have produced a load with valid low; nothing more to do.
                end
            end else begin
                ld = $urandom_range(0, 1);
                f3 = ld ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
                if ($urandom_range(0, 3) != 0) a = a - (a % access_bytes(f3));
                do_op(1, ld, !ld, f3, a, $urandom, $urandom_range(1, 4), $urandom, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the RV32I pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns load/store instructions into data-memory requests: word-aligned address, byte masks, shifted write data. Runs a request/response handshake with the data memory.
- Sign- or zero-extends load data and selects the value passed to writeback.
- Asserts a stall that freezes the whole pipeline until the memory op completes.

Parameters:
- None. RV32 widths are fixed: 32-bit address/data, 4-bit byte masks.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  instruction at EX/MEM output is valid
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store
- ex_funct3  in  3  width/sign encoding (RV32I funct3)
- ex_alu_out  in  32  effective address for memory ops; result for all others
- ex_rs2_data  in  32  store source data
- dmem_addr  out  32  word-aligned request address
- dmem_rmask  out  4  read byte mask; nonzero means read request
- dmem_wmask  out  4  write byte mask; nonzero means write request
- dmem_wdata  out  32  lane-shifted write data
- dmem_rdata  in  32  read data, valid when dmem_resp=1
- dmem_resp  in  1  one-cycle completion pulse from memory
- mem_wb_data  out  32  value to MEM/WB: extended load data, or ex_alu_out
- mem_stall  out  1  high means hold all pipeline registers (drives their load low)
- mem_misaligned  out  1  current memory op is misaligned and is being dropped

Behaviour:
- States: IDLE, REQ, DONE.
- Reset:
  - State becomes IDLE.
  - dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, the captured-rdata register and the latched op fields are all 0.
  - Outputs settle to: mem_stall=0, mem_misaligned=0, mem_wb_data=ex_alu_out.
- Alignment rules (a = ex_alu_out[1:0]):
  - funct3 x01 (H/HU) needs a[0]=0.
  - funct3 010 (W) needs a=00.
  - funct3 x00 (B/BU) is always aligned.
- IDLE:
  - Aligned memory op (ex_valid & (ex_is_load | ex_is_store) & aligned): mem_stall=1. Latch the address, funct3, load flag and store data. Registered request outputs are loaded for the next cycle. Go to REQ.
  - Misaligned memory op: mem_misaligned=1, mem_stall=0, no request, stay IDLE. mem_wb_data=ex_alu_out.
  - Non-memory op or ex_valid=0: mem_stall=0, no request, mem_wb_data=ex_alu_out.
  - dmem_resp is ignored in IDLE.
- REQ:
  - mem_stall=1. Request outputs are held stable until dmem_resp.
  - dmem_addr = {addr[31:2],2'b00}.
  - Loads: dmem_rmask = B 0001<<a, H 0011<<a, W 1111.
  - Stores: dmem_wmask uses the same encoding; dmem_wdata = rs2_data << (8*a).
  - The inactive mask is 0.
  - On dmem_resp: capture dmem_rdata, clear both masks to 0 at the edge, go to DONE.
- DONE:
  - mem_stall=0, so the pipeline advances at the end of this cycle. Next state IDLE.
  - For loads, mem_wb_data = captured word >> (8*a), then extended:
    - LB: sign-extend bit 7
    - LBU: zero-extend byte
    - LH: sign-extend bit 15
    - LHU: zero-extend halfword
    - LW: full word
  - For stores, mem_wb_data=ex_alu_out.
- Latency: a memory op arriving at cycle T with dmem_resp at cycle T+k (k≥1) has stall cycles T..T+k and DONE at T+k+1. Total occupancy is k+2 cycles. Non-memory ops take 1 cycle.
- Back-to-back memory ops:
  - The op entering after DONE starts a fresh IDLE→REQ sequence. No request is issued in DONE.
  - A request is never issued in two consecutive cycles without an intervening response.
- Reset in REQ (response outstanding): return to IDLE with masks 0. A late dmem_resp arriving after reset is ignored.
- EX/MEM inputs are frozen by mem_stall. All request fields and extension come from latched copies, so they do not depend on inputs staying stable.
- No flush input: older instructions in MEM are never squashed.

Test Plan:
- Reset: rst=1 for 2 cycles mid-REQ, then dmem_resp=1 one cycle after release -> state IDLE; masks stay 0000; mem_stall=0; mem_wb_data=ex_alu_out.
- LB with addr=0x1003 and memory returning 0x80_00_00_00 after k=3 -> dmem_addr=0x1000, dmem_rmask=1000, mem_stall high for 4 cycles, DONE mem_wb_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH with addr=0x2002, rs2=0x0000ABCD, k=1 -> dmem_addr=0x2000, dmem_wmask=1100, dmem_wdata=0xABCD0000, 3-cycle occupancy, mem_wb_data=0x2002.
- LW to addr=0x3001 -> mem_misaligned=1 for one cycle, no nonzero mask ever, mem_stall=0.
- ADD result 0x55 followed by back-to-back LW 0x40 / SW 0x44 with k=2 each -> ADD passes in 1 cycle; each memory op has exactly one mask-active window; LW mem_wb_data equals dmem_rdata.
- Spurious dmem_resp pulse while IDLE with a non-memory op -> no state change, mem_wb_data=ex_alu_out.
